// File: rtl/if_stage_fetch_if.sv
// Bundle of the fetch stage's control inputs, imem load port and IF/ID outputs.
// Handshake: if_id_valid qualifies if_id_instr/if_id_pc4 on every cycle; decode
// withholds acceptance by raising stall, which freezes PC and IF/ID until it drops.
interface if_stage_fetch_if #(
    parameter int IMEM_AW = 6
);
    logic [31:0]        PCIn;
    logic               stall;
    logic               flush;
    logic               branch_taken;
    logic [31:0]        branch_target;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_waddr;
    logic [31:0]        imem_wdata;

    logic [31:0]        pc_out;
    logic [31:0]        if_id_instr;
    logic [31:0]        if_id_pc4;
    logic               if_id_valid;
    logic               halted;
    logic [15:0]        fetch_count;
    logic               state_dbg;

    modport master (
        output PCIn, stall, flush, branch_taken, branch_target,
        output imem_we, imem_waddr, imem_wdata,
        input  pc_out, if_id_instr, if_id_pc4, if_id_valid, halted,
        input  fetch_count, state_dbg
    );

    modport slave (
        input  PCIn, stall, flush, branch_taken, branch_target,
        input  imem_we, imem_waddr, imem_wdata,
        output pc_out, if_id_instr, if_id_pc4, if_id_valid, halted,
        output fetch_count, state_dbg
    );
endinterface

// File: rtl/if_stage_fetch.sv
// MIPS instruction-fetch stage: PC, word-addressed imem, IF/ID register and a
// RUN/HALT FSM with branch > flush > stall priority.
module if_stage_fetch #(
    parameter int          IMEM_DEPTH  = 64,
    parameter int          IMEM_AW     = 6,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic              clk,
    input  logic              reset,
    if_stage_fetch_if.slave   bus
);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] instr_q, instr_nx;
    logic [31:0] pc4_q, pc4_nx;
    logic        valid_q, valid_nx;
    logic [15:0] count_q, count_nx;

    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] fetched;
    logic [31:0] pc_plus4;
    logic        is_halt;

    // Loading port is deliberately outside reset so a program survives a reset.
    always_ff @(posedge clk) begin
        if (bus.imem_we) begin
            imem[bus.imem_waddr] <= bus.imem_wdata;
        end
    end

    // Read is asynchronous, so a same-cycle write is only seen on the next fetch.
    assign fetched  = imem[pc[IMEM_AW+1:2]];
    assign pc_plus4 = pc + 32'd4;
    assign is_halt  = (fetched[31:26] == HALT_OPCODE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_RUN;
            pc      <= bus.PCIn;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            count_q <= 16'd0;
        end else begin
            state   <= state_nx;
            pc      <= pc_nx;
            instr_q <= instr_nx;
            pc4_q   <= pc4_nx;
            valid_q <= valid_nx;
            count_q <= count_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        instr_nx = instr_q;
        pc4_nx   = pc4_q;
        valid_nx = valid_q;
        count_nx = count_q;

        if (bus.branch_taken) begin
            // The branch is older than whatever is stalled or halted, so it wins.
            pc_nx    = bus.branch_target & ~32'd3;
            instr_nx = NOP_INSTR;
            valid_nx = 1'b0;
            state_nx = S_RUN;
        end else if (bus.flush) begin
            instr_nx = NOP_INSTR;
            valid_nx = 1'b0;
            if (state == S_RUN) begin
                pc_nx = pc_plus4;
            end
        end else if (bus.stall) begin
            pc_nx = pc;
        end else if (state == S_RUN) begin
            instr_nx = fetched;
            pc4_nx   = pc_plus4;
            valid_nx = 1'b1;
            count_nx = count_q + 16'd1;
            if (is_halt) begin
                // Halt word is handed to decode, but fetch parks on it.
                state_nx = S_HALT;
            end else begin
                pc_nx = pc_plus4;
            end
        end else begin
            instr_nx = NOP_INSTR;
            valid_nx = 1'b0;
        end
    end

    assign bus.pc_out      = pc;
    assign bus.if_id_instr = instr_q;
    assign bus.if_id_pc4   = pc4_q;
    assign bus.if_id_valid = valid_q;
    assign bus.fetch_count = count_q;
    assign bus.halted      = (state == S_HALT);
    assign bus.state_dbg   = state;

endmodule
